activation_layer_scheduler: RTL and testbench

//  Sequences the activation fetch unit (activationsTop) across a network run.

---
 rtl/activation_layer_scheduler.sv | 169 ++++++++++++++++
 tb/tb_activation_layer_scheduler.sv | 278 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/activation_layer_scheduler.sv
// Sequences the activation fetch unit across the layers and batches of a network run,
// using a small per-layer descriptor table loaded while the scheduler is idle.
module activation_layer_scheduler #(
  parameter int MAX_LAYERS = 16,
  parameter int TO_W       = 16,
  localparam int LW        = $clog2(MAX_LAYERS)
) (
  input  logic          clk,
  input  logic          resetn,
  input  logic          cfg_we,
  input  logic [LW-1:0] cfg_addr,
  input  logic [21:0]   cfg_data,
  input  logic [LW:0]   num_layers,
  input  logic          go,
  input  logic          abort,
  input  logic          fetch_done,
  input  logic          array_ready,
  output logic          start,
  output logic [10:0]   addr_start,
  output logic [4:0]    last_row,
  output logic [5:0]    batch,
  output logic [LW-1:0] cur_layer,
  output logic          busy,
  output logic          done,
  output logic          err
);

  typedef enum logic [2:0] {
    S_IDLE, S_LOAD, S_ISSUE, S_WAIT_FETCH, S_WAIT_ARRAY, S_FINISH
  } state_t;

  state_t          state;
  logic [21:0]     table_mem [MAX_LAYERS];
  logic [21:0]     desc_q;
  logic [LW-1:0]   layer_q;
  logic [5:0]      batch_q;
  logic [LW:0]     nl_q;
  logic [TO_W-1:0] to_cnt;

  logic [LW:0]     layer_inc;
  logic            last_layer;
  logic [6:0]      batch_inc;
  logic            more_batches;

  assign busy         = (state != S_IDLE);
  assign layer_inc    = {1'b0, layer_q} + {{LW{1'b0}}, 1'b1};
  assign last_layer   = (layer_inc == nl_q);
  assign batch_inc    = {1'b0, batch_q} + 7'd1;
  assign more_batches = (batch_inc < {1'b0, desc_q[5:0]});

  // NOTE: the descriptor table has no reset; its contents are only meaningful
  // after configuration, and leaving it out keeps it mappable to plain RAM.
  always_ff @(posedge clk) begin
    if (cfg_we && !busy) table_mem[cfg_addr] <= cfg_data;
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state      <= S_IDLE;
      desc_q     <= '0;
      layer_q    <= '0;
      batch_q    <= '0;
      nl_q       <= '0;
      to_cnt     <= '0;
      start      <= 1'b0;
      addr_start <= '0;
      last_row   <= '0;
      batch      <= '0;
      cur_layer  <= '0;
      done       <= 1'b0;
      err        <= 1'b0;
    end else begin
      // NOTE: pulse outputs default low here so every branch below only has to
      // raise them; all state uses non-blocking updates so branches see old values.
      start <= 1'b0;
      done  <= 1'b0;
      if (abort) begin
        state <= S_IDLE;
      end else begin
        case (state)
          S_IDLE: begin
            if (go) begin
              err     <= 1'b0;
              nl_q    <= num_layers;
              layer_q <= '0;
              batch_q <= '0;
              desc_q  <= table_mem[0];
              if (num_layers == '0) begin
                done  <= 1'b1;
                state <= S_FINISH;
              end else begin
                state <= S_LOAD;
              end
            end
          end

          S_LOAD: begin
            if (desc_q[5:0] == 6'd0) begin
              batch_q <= '0;
              if (last_layer) begin
                done  <= 1'b1;
                state <= S_FINISH;
              end else begin
                layer_q <= layer_inc[LW-1:0];
                desc_q  <= table_mem[layer_inc[LW-1:0]];
                state   <= S_LOAD;
              end
            end else begin
              start      <= 1'b1;
              addr_start <= desc_q[21:11];
              last_row   <= desc_q[10:6];
              batch      <= batch_q;
              cur_layer  <= layer_q;
              state      <= S_ISSUE;
            end
          end

          S_ISSUE: begin
            // Counting starts at 1 so the all-ones value is hit after exactly
            // 2**TO_W-1 cycles spent waiting on the fetch unit.
            to_cnt <= {{(TO_W-1){1'b0}}, 1'b1};
            state  <= S_WAIT_FETCH;
          end

          S_WAIT_FETCH: begin
            if (fetch_done) begin
              state <= S_WAIT_ARRAY;
            end else if (&to_cnt) begin
              err   <= 1'b1;
              done  <= 1'b1;
              state <= S_FINISH;
            end else begin
              to_cnt <= to_cnt + 1'b1;
            end
          end

          S_WAIT_ARRAY: begin
            if (array_ready) begin
              if (more_batches) begin
                batch_q    <= batch_inc[5:0];
                start      <= 1'b1;
                addr_start <= desc_q[21:11];
                last_row   <= desc_q[10:6];
                batch      <= batch_inc[5:0];
                cur_layer  <= layer_q;
                state      <= S_ISSUE;
              end else begin
                batch_q <= '0;
                if (last_layer) begin
                  done  <= 1'b1;
                  state <= S_FINISH;
                end else begin
                  layer_q <= layer_inc[LW-1:0];
                  desc_q  <= table_mem[layer_inc[LW-1:0]];
                  state   <= S_LOAD;
                end
              end
            end
          end

          S_FINISH: state <= S_IDLE;

          default: state <= S_IDLE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_activation_layer_scheduler.sv
// Directed bench for activation_layer_scheduler: single/multi-layer runs, array
// back-pressure, fetch timeout, abort, and configuration/go while busy.
module tb_activation_layer_scheduler;

  localparam int ML = 16;
  localparam int TW = 4;
  localparam int LW = 4;

  logic          clk = 1'b0;
  logic          resetn = 1'b0;
  logic          cfg_we = 1'b0;
  logic [LW-1:0] cfg_addr = '0;
  logic [21:0]   cfg_data = '0;
  logic [LW:0]   num_layers = '0;
  logic          go = 1'b0;
  logic          abort = 1'b0;
  logic          fetch_done = 1'b0;
  logic          array_ready = 1'b1;
  logic          start;
  logic [10:0]   addr_start;
  logic [4:0]    last_row;
  logic [5:0]    batch;
  logic [LW-1:0] cur_layer;
  logic          busy;
  logic          done;
  logic          err;

  int total = 0;
  int bad   = 0;
  int st_layer [8];
  int st_addr  [8];
  int st_batch [8];
  int st_row   [8];
  int n_start;
  int n_done;
  int viol;

  activation_layer_scheduler #(.MAX_LAYERS(ML), .TO_W(TW)) dut (
    .clk(clk), .resetn(resetn), .cfg_we(cfg_we), .cfg_addr(cfg_addr),
    .cfg_data(cfg_data), .num_layers(num_layers), .go(go), .abort(abort),
    .fetch_done(fetch_done), .array_ready(array_ready), .start(start),
    .addr_start(addr_start), .last_row(last_row), .batch(batch),
    .cur_layer(cur_layer), .busy(busy), .done(done), .err(err)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [21:0] desc(input logic [10:0] a, input logic [4:0] r,
                                       input logic [5:0] nb);
    return {a, r, nb};
  endfunction

  task automatic write_desc(input int idx, input logic [21:0] d);
    cfg_we   = 1'b1;
    cfg_addr = idx[LW-1:0];
    cfg_data = d;
    tick();
    cfg_we   = 1'b0;
  endtask

  task automatic pulse_go(input int n);
    num_layers = n[LW:0];
    go = 1'b1;
    tick();
    go = 1'b0;
  endtask

  task automatic fetch_pulse();
    fetch_done = 1'b1;
    tick();
    fetch_done = 1'b0;
  endtask

  // Runs to the end of the current run, answering each start with fetch_done
  // two cycles into WAIT_FETCH; first_cd primes a fetch for an already-issued batch.
  task automatic run(input int budget, input int first_cd);
    int cd;
    cd = first_cd;
    n_start = 0;
    n_done  = 0;
    for (int i = 0; i < budget; i++) begin
      tick();
      fetch_done = 1'b0;
      if (start) begin
        if (n_start < 8) begin
          st_layer[n_start] = int'(cur_layer);
          st_addr[n_start]  = int'(addr_start);
          st_batch[n_start] = int'(batch);
          st_row[n_start]   = int'(last_row);
        end
        n_start++;
        cd = 2;
      end else if (cd > 0) begin
        cd--;
        if (cd == 0) fetch_done = 1'b1;
      end
      if (done) n_done++;
      if (!busy && n_done > 0) break;
    end
    fetch_done = 1'b0;
  endtask

  initial begin
    // Reset state
    #2;
    check("rst_start", start, 1'b0);
    check("rst_busy", busy, 1'b0);
    check("rst_done", done, 1'b0);
    check("rst_err", err, 1'b0);
    check("rst_addr", addr_start, 11'h000);
    check("rst_row", last_row, 5'd0);
    check("rst_batch", batch, 6'd0);
    check("rst_layer", cur_layer, 4'd0);
    #10 resetn = 1'b1;
    tick();

    // 1: one layer, two batches, fetch_done 5 cycles after each start
    write_desc(0, desc(11'h010, 5'd7, 6'd2));
    pulse_go(1);
    check("t1_busy_load", busy, 1'b1);
    tick();
    check("t1_start0", start, 1'b1);
    check("t1_addr0", addr_start, 11'h010);
    check("t1_row0", last_row, 5'd7);
    check("t1_batch0", batch, 6'd0);
    tick();
    check("t1_start_low", start, 1'b0);
    repeat (3) tick();
    fetch_pulse();
    tick();
    check("t1_start1", start, 1'b1);
    check("t1_batch1", batch, 6'd1);
    check("t1_addr1", addr_start, 11'h010);
    tick();
    repeat (3) tick();
    fetch_pulse();
    check("t1_no_done_yet", done, 1'b0);
    tick();
    check("t1_done", done, 1'b1);
    check("t1_busy_finish", busy, 1'b1);
    tick();
    check("t1_done_pulse", done, 1'b0);
    check("t1_idle", busy, 1'b0);
    check("t1_hold_batch", batch, 6'd1);

    // 3: array back-pressure for 20 cycles after fetch_done
    pulse_go(1);
    tick();
    tick();
    array_ready = 1'b0;
    fetch_pulse();
    viol = 0;
    for (int i = 0; i < 20; i++) begin
      tick();
      if (start !== 1'b0 || busy !== 1'b1) viol++;
    end
    check("t3_stall", viol, 0);
    array_ready = 1'b1;
    tick();
    check("t3_start_after_ready", start, 1'b1);
    check("t3_batch", batch, 6'd1);
    tick();
    fetch_pulse();
    tick();
    check("t3_done", done, 1'b1);
    tick();

    // 4: fetch timeout after 15 cycles in WAIT_FETCH
    pulse_go(1);
    tick();
    check("t4_start", start, 1'b1);
    repeat (15) tick();
    check("t4_no_done_at_15", done, 1'b0);
    check("t4_busy_at_15", busy, 1'b1);
    check("t4_no_err_at_15", err, 1'b0);
    tick();
    check("t4_done", done, 1'b1);
    check("t4_err", err, 1'b1);
    tick();
    check("t4_idle", busy, 1'b0);
    check("t4_err_sticky", err, 1'b1);
    pulse_go(0);
    check("t6_zero_done", done, 1'b1);
    check("t4_err_cleared", err, 1'b0);
    tick();
    check("t6_zero_idle", busy, 1'b0);

    // 5: abort during batch 1 of layer 0, then restart
    pulse_go(1);
    tick();
    tick();
    fetch_pulse();
    tick();
    check("t5_batch1", batch, 6'd1);
    tick();
    abort = 1'b1;
    tick();
    abort = 1'b0;
    check("t5_abort_idle", busy, 1'b0);
    check("t5_abort_start", start, 1'b0);
    check("t5_abort_nodone", done, 1'b0);
    check("t5_abort_hold_batch", batch, 6'd1);
    check("t5_abort_hold_addr", addr_start, 11'h010);
    tick();
    check("t5_abort_nodone2", done, 1'b0);
    num_layers = 5'd1;
    go = 1'b1;
    abort = 1'b1;
    tick();
    go = 1'b0;
    abort = 1'b0;
    check("t5_abort_wins", busy, 1'b0);
    pulse_go(1);
    tick();
    check("t5_restart_start", start, 1'b1);
    check("t5_restart_batch", batch, 6'd0);
    check("t5_restart_layer", cur_layer, 4'd0);
    run(100, 2);
    check("t5_rest_starts", n_start, 1);
    check("t5_rest_done", n_done, 1);

    // 6: configuration write and go while busy are ignored
    pulse_go(1);
    cfg_we   = 1'b1;
    cfg_addr = 4'd0;
    cfg_data = desc(11'h7FF, 5'd1, 6'd1);
    go = 1'b1;
    tick();
    cfg_we = 1'b0;
    go = 1'b0;
    check("t6_start", start, 1'b1);
    check("t6_addr", addr_start, 11'h010);
    run(100, 2);
    check("t6_go_ignored_starts", n_start, 1);
    check("t6_go_ignored_batch", st_batch[0], 1);
    check("t6_done", n_done, 1);
    pulse_go(1);
    run(100, 0);
    check("t6_rerun_starts", n_start, 2);
    check("t6_rerun_addr", st_addr[0], 32'h010);
    check("t6_rerun_row", st_row[0], 7);

    // 2: three layers with the middle one empty
    write_desc(0, desc(11'h100, 5'd3, 6'd1));
    write_desc(1, desc(11'h200, 5'd4, 6'd0));
    write_desc(2, desc(11'h300, 5'd5, 6'd2));
    pulse_go(3);
    run(200, 0);
    check("t2_starts", n_start, 3);
    check("t2_done", n_done, 1);
    check("t2_layer0", st_layer[0], 0);
    check("t2_layer1", st_layer[1], 2);
    check("t2_layer2", st_layer[2], 2);
    check("t2_addr0", st_addr[0], 32'h100);
    check("t2_addr1", st_addr[1], 32'h300);
    check("t2_row1", st_row[1], 5);
    check("t2_batch1", st_batch[1], 0);
    check("t2_batch2", st_batch[2], 1);
    check("t2_err", err, 1'b0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
